board_state_ctrl: RTL and testbench
===================================

Name: board_state_ctrl

Overview:
- Game-logic writer for the board that the rectangle/square drawing chain reads.
- Converts mouse position plus left-click into cell moves and alternates players.
- Detects a win or a draw.
- Drives the registered `square1to9` (occupied) and `square1to9_color` (owner) vectors consumed by the draw pipeline, with status outputs for the game FSM.

Parameters:
- BOARD_X0, 212, left pixel of cell column 0
- BOARD_Y0, 84, top pixel of cell row 0
- CELL_SIZE, 200, cell width/height in pixels (board spans 3*CELL_SIZE)

Ports:
- pclk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- xpos  in  12  mouse X, pclk domain
- ypos  in  12  mouse Y, pclk domain
- mouse_left  in  1  left button level, pclk domain
- start_en  in  1  1 = game running requested
- choice_en  in  1  first-mover colour, sampled at game start
- square1to9  out  9  bit i = cell i occupied; i = row*3+col, bit0 top-left
- square1to9_color  out  9  bit i = owner colour of cell i (valid only when occupied)
- current_player  out  1  colour to move next
- game_over  out  1  1 in DONE state
- winner  out  2  00 none, 01 colour 0, 10 colour 1, 11 draw
- win_mask  out  9  winning-line cells (see Optional Feature)

Behaviour:
- **Reset:** all outputs and internal registers are 0; state is IDLE; the click edge register `btn_q` is 0. rst has priority over every other event.
- **Click edge:** `click = mouse_left & ~btn_q`; `btn_q <= mouse_left` every cycle.
- **Cell decode** (combinational, no division):
  - col c is valid when `BOARD_X0 + c*CELL_SIZE <= xpos < BOARD_X0 + (c+1)*CELL_SIZE`; row r likewise on ypos.
  - Outside the board: `cell_valid = 0`.
  - Comparisons are 13-bit unsigned to avoid overflow.
- **FSM** states IDLE, PLAY, CHECK, DONE:
  - IDLE:
    - `start_en = 1` → PLAY.
    - On that transition: clear `square1to9` and `square1to9_color`; `current_player <= choice_en`; `winner <= 00`.
    - The board is otherwise retained in IDLE, so the last game stays visible.
  - PLAY:
    - `start_en = 0` → IDLE (abort, board kept).
    - Else if click, `cell_valid`, and target bit not occupied: set `square1to9[idx]`; `square1to9_color[idx] <= current_player`; → CHECK.
    - A click on an occupied cell or off the board is ignored; stay in PLAY.
  - CHECK (exactly 1 cycle). Evaluate the 8 line masks against the registered board: 0x007, 0x038, 0x1C0, 0x049, 0x092, 0x124, 0x111, 0x054. A line is won when all its cells are occupied and share one colour.
    - Win: `winner <= {colour==1, colour==0}` → DONE.
    - Else if `square1to9 == 9'h1FF`: `winner <= 11` → DONE.
    - Else: `current_player <= ~current_player` → PLAY.
  - DONE:
    - `game_over = 1`; the board is frozen and clicks are ignored.
    - `start_en = 0` → IDLE, which clears `game_over`.
- **Latency:** click edge detected in cycle N → board bit visible in cycle N+1 → winner/`current_player` update visible in cycle N+2.
- **Click-edge consumption:** a click edge arriving during CHECK or DONE is consumed and never replayed. A held button produces only one move.
- **Reset mid-game:** rst returns to IDLE with an empty board, regardless of state.
- **Win and full board in the same CHECK:** win takes precedence over draw.

Optional Feature:
- **Macro:** `BOARD_WIN_MASK_EN`.
- **Defined:**
  - `win_mask` registers the first matching line mask, in the priority order listed under CHECK, when entering DONE with a win.
  - It is 0 for a draw, and cleared on the IDLE→PLAY transition and on rst.
- **Undefined:** `win_mask` is tied to 9'h000 and no line-mask register is synthesized.

Decomposition:
- **Shared package** (board_pkg):
  - state encoding constants;
  - winner codes (WIN_NONE, WIN_C0, WIN_C1, WIN_DRAW);
  - the 8 win line masks as a constant array;
  - NUM_CELLS = 9.
- **Sub-module:** board_cell_decode (purely combinational).
  - Inputs: xpos, ypos.
  - Outputs: `cell_idx[3:0]`, `cell_valid`.
  - Parameterised by BOARD_X0, BOARD_Y0, CELL_SIZE.
- The FSM and win check stay in board_state_ctrl.

Test Plan:
- Reset, then start_en=1, choice_en=0, click at (312,184) → cycle N+1: `square1to9=9'h001`, `square1to9_color=9'h000`; N+2: `current_player=1`, `winner=00`.
- Moves alternate cells 0,3,1,4,2 (colour 0 on 0,1,2) → after the 5th CHECK: `winner=01`, `game_over=1`, `win_mask=9'h007` with BOARD_WIN_MASK_EN (9'h000 without).
- Click at (100,100) (off board) and a repeat click on occupied cell 0 → board unchanged, state PLAY, `current_player` unchanged.
- Fill the board with no line (order 0,1,2,4,3,5,7,6,8, choice_en=0) → `winner=11`, `square1to9=9'h1FF`, `game_over=1`.
- Hold mouse_left high for 50 cycles over an empty cell → exactly one bit set; a click during DONE → no change.
- Assert rst in PLAY with 4 cells set → next cycle all outputs 0, state IDLE; deassert start_en in PLAY → IDLE with board kept.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the tic-tac-toe board controller.
//   - state_e      : controller FSM states
//   - WIN_*        : winner status codes driven on board_state_ctrl.winner
//   - WIN_LINES    : the 8 winning line masks, in win-priority order (index 0 first)
//   - NUM_CELLS    : number of board cells (bit i = row*3+col)
package board_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StCheck = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_C0   = 2'b01;
    localparam logic [1:0] WIN_C1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Rows, columns, main diagonal, anti-diagonal; WIN_LINES[0] = 9'h007.
    localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] WIN_LINES = {
        9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
    };

endpackage

// File: rtl/board_cell_decode.sv
// board_cell_decode: maps a mouse position onto a board cell (purely combinational).
// Ports:
//   xpos, ypos  in  12  mouse position in pixels
//   cell_idx    out 4   row*3+col of the hovered cell (0 when off the board)
//   cell_valid  out 1   1 when the position lies inside the 3x3 board
// Parameters: BOARD_X0/BOARD_Y0 top-left pixel of the board, CELL_SIZE cell edge in pixels.
module board_cell_decode #(
    parameter int unsigned BOARD_X0  = 212,
    parameter int unsigned BOARD_Y0  = 84,
    parameter int unsigned CELL_SIZE = 200
) (
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [3:0]  cell_idx,
    output logic        cell_valid
);

    // Column/row boundaries widened to 13 bits so BOARD_*0 + 3*CELL_SIZE cannot wrap.
    localparam logic [12:0] X_B0 = 13'(BOARD_X0);
    localparam logic [12:0] X_B1 = 13'(BOARD_X0 + CELL_SIZE);
    localparam logic [12:0] X_B2 = 13'(BOARD_X0 + 2 * CELL_SIZE);
    localparam logic [12:0] X_B3 = 13'(BOARD_X0 + 3 * CELL_SIZE);
    localparam logic [12:0] Y_B0 = 13'(BOARD_Y0);
    localparam logic [12:0] Y_B1 = 13'(BOARD_Y0 + CELL_SIZE);
    localparam logic [12:0] Y_B2 = 13'(BOARD_Y0 + 2 * CELL_SIZE);
    localparam logic [12:0] Y_B3 = 13'(BOARD_Y0 + 3 * CELL_SIZE);

    logic [12:0] x_ext;
    logic [12:0] y_ext;
    logic [1:0]  col;
    logic [1:0]  row;
    logic        col_ok;
    logic        row_ok;

    assign x_ext = {1'b0, xpos};
    assign y_ext = {1'b0, ypos};

    always_comb begin
        col    = 2'd0;
        col_ok = 1'b1;
        if (x_ext >= X_B0 && x_ext < X_B1) begin
            col = 2'd0;
        end else if (x_ext >= X_B1 && x_ext < X_B2) begin
            col = 2'd1;
        end else if (x_ext >= X_B2 && x_ext < X_B3) begin
            col = 2'd2;
        end else begin
            col_ok = 1'b0;
        end

        row    = 2'd0;
        row_ok = 1'b1;
        if (y_ext >= Y_B0 && y_ext < Y_B1) begin
            row = 2'd0;
        end else if (y_ext >= Y_B1 && y_ext < Y_B2) begin
            row = 2'd1;
        end else if (y_ext >= Y_B2 && y_ext < Y_B3) begin
            row = 2'd2;
        end else begin
            row_ok = 1'b0;
        end

        cell_valid = col_ok & row_ok;
        // row*3 = row*2 + row
        cell_idx   = cell_valid ? (4'({row, 1'b0}) + 4'(row) + 4'(col)) : 4'd0;
    end

endmodule

// File: rtl/board_state_ctrl.sv
// board_state_ctrl: game logic writing the board read by the square drawing pipeline.
// Turns mouse left-click edges into moves, alternates players, detects win/draw.
// Ports:
//   pclk, rst          pixel clock, synchronous active-high reset
//   xpos, ypos         mouse position (pclk domain)
//   mouse_left         left button level
//   start_en           1 = game running requested; 0 returns to IDLE
//   choice_en          colour of the first mover, sampled on IDLE->PLAY
//   square1to9         occupied cells (bit i = row*3+col)
//   square1to9_color   owner colour of each occupied cell
//   current_player     colour to move next
//   game_over          1 while in DONE
//   winner             00 none, 01 colour 0, 10 colour 1, 11 draw
//   win_mask           winning line cells when BOARD_WIN_MASK_EN is defined, else 0
// Optional feature macro: BOARD_WIN_MASK_EN.
module board_state_ctrl
    import board_pkg::*;
#(
    parameter int unsigned BOARD_X0  = 212,
    parameter int unsigned BOARD_Y0  = 84,
    parameter int unsigned CELL_SIZE = 200
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    input  logic        start_en,
    input  logic        choice_en,
    output logic [8:0]  square1to9,
    output logic [8:0]  square1to9_color,
    output logic        current_player,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [8:0]  win_mask
);

    state_e     state_q;
    logic       btn_q;
    logic       click;
    logic [3:0] cell_idx;
    logic       cell_valid;
    logic       line_won;
    logic       line_colour;
`ifdef BOARD_WIN_MASK_EN
    logic [8:0] line_mask;
    logic [8:0] win_mask_q;
`endif

    board_cell_decode #(
        .BOARD_X0  (BOARD_X0),
        .BOARD_Y0  (BOARD_Y0),
        .CELL_SIZE (CELL_SIZE)
    ) u_cell_decode (
        .xpos       (xpos),
        .ypos       (ypos),
        .cell_idx   (cell_idx),
        .cell_valid (cell_valid)
    );

    assign click = mouse_left & ~btn_q;

    // First fully-occupied single-colour line wins, in WIN_LINES order.
    always_comb begin
        line_won    = 1'b0;
        line_colour = 1'b0;
`ifdef BOARD_WIN_MASK_EN
        line_mask   = 9'h000;
`endif
        for (int i = 0; i < int'(NUM_LINES); i++) begin
            if (!line_won && ((square1to9 & WIN_LINES[i]) == WIN_LINES[i])) begin
                if ((square1to9_color & WIN_LINES[i]) == WIN_LINES[i]) begin
                    line_won    = 1'b1;
                    line_colour = 1'b1;
`ifdef BOARD_WIN_MASK_EN
                    line_mask   = WIN_LINES[i];
`endif
                end else if ((square1to9_color & WIN_LINES[i]) == 9'h000) begin
                    line_won    = 1'b1;
                    line_colour = 1'b0;
`ifdef BOARD_WIN_MASK_EN
                    line_mask   = WIN_LINES[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q          <= StIdle;
            btn_q            <= 1'b0;
            square1to9       <= 9'h000;
            square1to9_color <= 9'h000;
            current_player   <= 1'b0;
            game_over        <= 1'b0;
            winner           <= WIN_NONE;
`ifdef BOARD_WIN_MASK_EN
            win_mask_q       <= 9'h000;
`endif
        end else begin
            // Updated in every state, so edges seen in CHECK/DONE are dropped.
            btn_q <= mouse_left;
            unique case (state_q)
                StIdle: begin
                    if (start_en) begin
                        state_q          <= StPlay;
                        square1to9       <= 9'h000;
                        square1to9_color <= 9'h000;
                        current_player   <= choice_en;
                        winner           <= WIN_NONE;
`ifdef BOARD_WIN_MASK_EN
                        win_mask_q       <= 9'h000;
`endif
                    end
                end
                StPlay: begin
                    if (!start_en) begin
                        state_q <= StIdle;
                    end else if (click && cell_valid && !square1to9[cell_idx]) begin
                        square1to9[cell_idx]       <= 1'b1;
                        square1to9_color[cell_idx] <= current_player;
                        state_q                    <= StCheck;
                    end
                end
                StCheck: begin
                    if (line_won) begin
                        winner    <= {line_colour, ~line_colour};
                        game_over <= 1'b1;
                        state_q   <= StDone;
`ifdef BOARD_WIN_MASK_EN
                        win_mask_q <= line_mask;
`endif
                    end else if (&square1to9) begin
                        winner    <= WIN_DRAW;
                        game_over <= 1'b1;
                        state_q   <= StDone;
`ifdef BOARD_WIN_MASK_EN
                        win_mask_q <= 9'h000;
`endif
                    end else begin
                        current_player <= ~current_player;
                        state_q        <= StPlay;
                    end
                end
                StDone: begin
                    if (!start_en) begin
                        game_over <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef BOARD_WIN_MASK_EN
    assign win_mask = win_mask_q;
`else
    assign win_mask = 9'h000;
`endif

endmodule

// File: tb/tb_board_state_ctrl.sv
// tb_board_state_ctrl: self-checking bench for board_state_ctrl.
// Scripted vectors for the first game, hand-written corner sequences, then random play
// checked against a move-level tic-tac-toe model.
module tb_board_state_ctrl;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        start_en;
    logic        choice_en;
    logic [8:0]  square1to9;
    logic [8:0]  square1to9_color;
    logic        current_player;
    logic        game_over;
    logic [1:0]  winner;
    logic [8:0]  win_mask;

    always #5 pclk = ~pclk;

    board_state_ctrl #(
        .BOARD_X0  (212),
        .BOARD_Y0  (84),
        .CELL_SIZE (200)
    ) dut (
        .pclk             (pclk),
        .rst              (rst),
        .xpos             (xpos),
        .ypos             (ypos),
        .mouse_left       (mouse_left),
        .start_en         (start_en),
        .choice_en        (choice_en),
        .square1to9       (square1to9),
        .square1to9_color (square1to9_color),
        .current_player   (current_player),
        .game_over        (game_over),
        .winner           (winner),
        .win_mask         (win_mask)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Move-level game model.
    bit       m_occ [9];
    bit       m_own [9];
    bit       m_player;
    bit [1:0] m_winner;
    bit       m_over;
    bit [8:0] m_wmask;
    bit       m_running;
    int       lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                               '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

    typedef struct {
        int         x;
        int         y;
        logic [8:0] sq;
        logic [8:0] col;
        logic       p;
        logic [1:0] win;
        logic       over;
        logic [8:0] wm;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [8:0] m_sq();
        logic [8:0] v = '0;
        for (int i = 0; i < 9; i++) v[i] = m_occ[i];
        return v;
    endfunction

    function automatic logic [8:0] m_col();
        logic [8:0] v = '0;
        for (int i = 0; i < 9; i++) v[i] = m_occ[i] & m_own[i];
        return v;
    endfunction

    function automatic logic [8:0] exp_wm(input logic [8:0] wm);
`ifdef BOARD_WIN_MASK_EN
        return wm;
`else
        return 9'h000 & wm;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) begin
            m_occ[i] = 0;
            m_own[i] = 0;
        end
        m_player  = 0;
        m_winner  = 0;
        m_over    = 0;
        m_wmask   = 0;
        m_running = 0;
    endfunction

    function automatic void model_start(input bit choice);
        model_reset();
        m_player  = choice;
        m_running = 1;
    endfunction

    function automatic void model_stop();
        m_running = 0;
        m_over    = 0;
    endfunction

    function automatic void model_click(input int x, input int y);
        int  idx;
        bit  won;
        bit  full;
        if (!m_running || m_over) return;
        if (x < 212 || x >= 812 || y < 84 || y >= 684) return;
        idx = ((y - 84) / 200) * 3 + (x - 212) / 200;
        if (m_occ[idx]) return;
        m_occ[idx] = 1;
        m_own[idx] = m_player;
        won = 0;
        foreach (lines[l]) begin
            int a = lines[l][0];
            int b = lines[l][1];
            int c = lines[l][2];
            if (!won && m_occ[a] && m_occ[b] && m_occ[c] &&
                m_own[a] == m_own[b] && m_own[b] == m_own[c]) begin
                won      = 1;
                m_winner = m_own[a] ? 2'b10 : 2'b01;
                m_wmask  = '0;
                m_wmask[a] = 1;
                m_wmask[b] = 1;
                m_wmask[c] = 1;
            end
        end
        full = 1;
        for (int i = 0; i < 9; i++) full &= m_occ[i];
        if (won) begin
            m_over = 1;
        end else if (full) begin
            m_winner = 2'b11;
            m_wmask  = 0;
            m_over   = 1;
        end else begin
            m_player = ~m_player;
        end
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " square1to9"}, square1to9, m_sq());
        chk({tag, " color"}, square1to9_color, m_col());
        chk({tag, " current_player"}, 9'(current_player), 9'(m_player));
        chk({tag, " winner"}, 9'(winner), 9'(m_winner));
        chk({tag, " game_over"}, 9'(game_over), 9'(m_over));
        chk({tag, " win_mask"}, win_mask, exp_wm(m_wmask));
    endtask

    task automatic do_click(input int x, input int y);
        xpos       = 12'(x);
        ypos       = 12'(y);
        mouse_left = 1'b1;
        tick();
        mouse_left = 1'b0;
        tick();
        tick();
        tick();
        model_click(x, y);
    endtask

    task automatic click_cell(input int c);
        do_click(312 + 200 * (c % 3), 184 + 200 * (c / 3));
    endtask

    task automatic start_game(input bit choice);
        start_en = 1'b0;
        tick();
        tick();
        choice_en = choice;
        start_en  = 1'b1;
        tick();
        tick();
        model_stop();
        model_start(choice);
    endtask

    task automatic stop_game();
        start_en = 1'b0;
        tick();
        tick();
        model_stop();
    endtask

    task automatic do_reset();
        start_en = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " square1to9"}, square1to9, 9'h000);
        chk({tag, " color"}, square1to9_color, 9'h000);
        chk({tag, " current_player"}, 9'(current_player), 9'h000);
        chk({tag, " winner"}, 9'(winner), 9'h000);
        chk({tag, " game_over"}, 9'(game_over), 9'h000);
        chk({tag, " win_mask"}, win_mask, 9'h000);
    endtask

    initial begin
        // x, y, square1to9, color, player, winner, game_over, win_mask (feature on)
        tbl[0]  = '{100, 100, 9'h001, 9'h000, 1'b1, 2'b00, 1'b0, 9'h000};
        tbl[1]  = '{312, 184, 9'h001, 9'h000, 1'b1, 2'b00, 1'b0, 9'h000};
        tbl[2]  = '{211, 184, 9'h001, 9'h000, 1'b1, 2'b00, 1'b0, 9'h000};
        tbl[3]  = '{312,  83, 9'h001, 9'h000, 1'b1, 2'b00, 1'b0, 9'h000};
        tbl[4]  = '{212, 483, 9'h009, 9'h008, 1'b0, 2'b00, 1'b0, 9'h000};
        tbl[5]  = '{412, 283, 9'h00B, 9'h008, 1'b1, 2'b00, 1'b0, 9'h000};
        tbl[6]  = '{812, 184, 9'h00B, 9'h008, 1'b1, 2'b00, 1'b0, 9'h000};
        tbl[7]  = '{611, 284, 9'h01B, 9'h018, 1'b0, 2'b00, 1'b0, 9'h000};
        tbl[8]  = '{312, 684, 9'h01B, 9'h018, 1'b0, 2'b00, 1'b0, 9'h000};
        tbl[9]  = '{811,  84, 9'h01F, 9'h018, 1'b0, 2'b01, 1'b1, 9'h007};
        tbl[10] = '{312, 584, 9'h01F, 9'h018, 1'b0, 2'b01, 1'b1, 9'h007};

        rst        = 1'b1;
        start_en   = 1'b0;
        choice_en  = 1'b0;
        mouse_left = 1'b0;
        xpos       = '0;
        ypos       = '0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        check_all_zero("reset");

        // First move latency: board at N+1, player toggle at N+2.
        choice_en = 1'b0;
        start_en  = 1'b1;
        tick();
        model_start(1'b0);
        xpos       = 12'd312;
        ypos       = 12'd184;
        mouse_left = 1'b1;
        tick();
        chk("lat N+1 square1to9", square1to9, 9'h001);
        chk("lat N+1 color", square1to9_color, 9'h000);
        chk("lat N+1 player", 9'(current_player), 9'h000);
        mouse_left = 1'b0;
        tick();
        chk("lat N+2 player", 9'(current_player), 9'h001);
        chk("lat N+2 winner", 9'(winner), 9'h000);
        chk("lat N+2 game_over", 9'(game_over), 9'h000);
        model_click(312, 184);
        tick();

        foreach (tbl[i]) begin
            do_click(tbl[i].x, tbl[i].y);
            chk($sformatf("vec%0d square1to9", i), square1to9, tbl[i].sq);
            chk($sformatf("vec%0d color", i), square1to9_color, tbl[i].col);
            chk($sformatf("vec%0d player", i), 9'(current_player), 9'(tbl[i].p));
            chk($sformatf("vec%0d winner", i), 9'(winner), 9'(tbl[i].win));
            chk($sformatf("vec%0d game_over", i), 9'(game_over), 9'(tbl[i].over));
            chk($sformatf("vec%0d win_mask", i), win_mask, exp_wm(tbl[i].wm));
        end

        // Draw: no line completed, board full.
        start_game(1'b0);
        begin
            int order [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
            foreach (order[k]) begin
                click_cell(order[k]);
                check_model($sformatf("draw%0d", k));
            end
        end
        chk("draw winner", 9'(winner), 9'h003);
        chk("draw square1to9", square1to9, 9'h1FF);
        chk("draw color", square1to9_color, 9'h072);
        chk("draw game_over", 9'(game_over), 9'h001);
        chk("draw win_mask", win_mask, 9'h000);

        // Held button: one move only.
        start_game(1'b1);
        xpos       = 12'd512;
        ypos       = 12'd384;
        mouse_left = 1'b1;
        repeat (50) tick();
        mouse_left = 1'b0;
        tick();
        tick();
        model_click(512, 384);
        chk("held square1to9", square1to9, 9'h010);
        chk("held bit count", 9'($countones(square1to9)), 9'h001);
        check_model("held");

        // Reset mid-game with four cells set.
        start_game(1'b0);
        click_cell(0);
        click_cell(1);
        click_cell(2);
        click_cell(4);
        chk("pre-rst square1to9", square1to9, 9'h017);
        do_reset();
        check_all_zero("mid rst");
        tick();
        check_all_zero("mid rst idle");

        // Abort: board kept, clicks in IDLE ignored.
        start_game(1'b0);
        click_cell(0);
        click_cell(4);
        stop_game();
        check_model("abort");
        click_cell(8);
        chk("abort square1to9", square1to9, 9'h011);
        chk("abort color", square1to9_color, 9'h010);
        check_model("abort idle click");

        // Random play against the model.
        start_game(1'($urandom_range(0, 1)));
        for (int it = 0; it < 400; it++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 3) begin
                do_reset();
                check_model("rnd rst");
                start_game(1'($urandom_range(0, 1)));
            end else if (r < 8 || (m_over && r < 40) || (!m_running && r < 50)) begin
                start_game(1'($urandom_range(0, 1)));
            end else if (r < 11) begin
                stop_game();
            end else if (r < 80) begin
                int c = int'($urandom_range(0, 8));
                do_click(212 + 200 * (c % 3) + int'($urandom_range(0, 199)),
                         84 + 200 * (c / 3) + int'($urandom_range(0, 199)));
            end else begin
                do_click(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end
            check_model($sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
